// File: rtl/rv32i_types.sv
// Shared RV32I core types: ALU op encoding, reservation-station and CDB payloads,
// and the ALU op table used by every unit that needs integer results.
package rv32i_types;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;

  typedef enum logic [4:0] {
    reg_add, reg_sub, reg_sll, reg_slt, reg_sltu, reg_xor, reg_srl, reg_sra,
    reg_or, reg_and, imm_addi, imm_slti, imm_sltiu, imm_xori, imm_ori,
    imm_andi, imm_slli, imm_srli, imm_srai, lui, auipc, jal
  } alu_op_t;

  typedef struct packed {
    alu_op_t          op;
    logic [XLEN-1:0]  q1_data;
    logic [XLEN-1:0]  q2_data;
    logic [ROB_W-1:0] rob_dest;
  } rs_alu_output_t;

  typedef struct packed {
    logic [XLEN-1:0]  rd_data;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [ROB_W-1:0] rob_entry;
  } cdb_t;

  // Undecoded ops return 0 so a bad encoding can never leak X onto the CDB.
  function automatic logic [XLEN-1:0] alu_compute(alu_op_t op, logic [XLEN-1:0] au,
                                                  logic [XLEN-1:0] bu);
    logic signed [XLEN-1:0] as_v;
    logic signed [XLEN-1:0] bs_v;
    logic [4:0]             sh;
    logic [XLEN-1:0]        f;
    as_v = au;
    bs_v = bu;
    sh   = bu[4:0];
    case (op)
      reg_add, imm_addi, lui, auipc: f = au + bu;
      reg_sub:                       f = au - bu;
      reg_sll, imm_slli:             f = au << sh;
      reg_srl, imm_srli:             f = au >> sh;
      reg_sra, imm_srai:             f = $unsigned(as_v >>> sh);
      reg_xor, imm_xori:             f = au ^ bu;
      reg_or,  imm_ori:              f = au | bu;
      reg_and, imm_andi:             f = au & bu;
      reg_slt, imm_slti:             f = {{(XLEN-1){1'b0}}, (as_v < bs_v)};
      reg_sltu, imm_sltiu:           f = {{(XLEN-1){1'b0}}, (au < bu)};
      jal:                           f = au + 32'd4;
      default:                       f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/result bundle between the ALU reservation station, the ALU unit and the CDB arbiter.
interface alu_pipe_if;
  import rv32i_types::*;

  rs_alu_output_t data;
  logic           rs_alu_start;
  logic           flush;
  logic           cdb_ready;
  logic           alu_ready;
  logic           alu_result_valid;
  cdb_t           result;

  modport master (output data, rs_alu_start, flush, cdb_ready,
                  input  alu_ready, alu_result_valid, result);
  modport slave  (input  data, rs_alu_start, flush, cdb_ready,
                  output alu_ready, alu_result_valid, result);
endinterface

// File: rtl/alu_result_fifo.sv
// Circular result buffer holding completed ALU results until the CDB takes them.
module alu_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  cdb_t wdata,
  output cdb_t rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two to wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined RV32I ALU functional unit: computes at issue, delays STAGES-1 cycles,
// and parks results in a FIFO until the CDB accepts them.
module alu_pipe
  import rv32i_types::*;
#(
  parameter int STAGES = 1,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] inflight;
  logic             issue;
  logic             pop;
  logic             push;
  cdb_t             res_p0;
  cdb_t             push_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign bus.alu_ready        = (inflight < CNT_W'(DEPTH));
  assign issue                = bus.rs_alu_start && bus.alu_ready;
  assign pop                  = bus.alu_result_valid && bus.cdb_ready;
  assign bus.alu_result_valid = !fifo_empty;

  // Stage 0: compute at issue, operands travel with the result
  always_comb begin
    res_p0           = '0;
    res_p0.rd_data   = alu_compute(bus.data.op, bus.data.q1_data, bus.data.q2_data);
    res_p0.rs1_data  = bus.data.q1_data;
    res_p0.rs2_data  = bus.data.q2_data;
    res_p0.rob_entry = bus.data.rob_dest;
  end

  if (STAGES == 1) begin : g_no_pipe
    assign push      = issue;
    assign push_data = res_p0;
  end else begin : g_pipe
    cdb_t res_p [1:STAGES-1];
    logic vld_p [1:STAGES-1];

    // Stages 1..STAGES-1: delay line, valid cleared on flush
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '{default: 1'b0};
      end else if (bus.flush) begin
        vld_p <= '{default: 1'b0};
      end else begin
        vld_p[1] <= issue;
        for (int i = 2; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      res_p[1] <= res_p0;
      for (int i = 2; i < STAGES; i++) res_p[i] <= res_p[i-1];
    end

    assign push      = vld_p[STAGES-1];
    assign push_data = res_p[STAGES-1];
  end

  // Counting issues rather than FIFO slots is what guarantees a free slot for every arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (bus.flush) begin
      inflight <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full));
  end

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (push_data),
    .rdata (bus.result),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against a queue-based issue/latency model.
module tb_alu_pipe;
  import rv32i_types::*;

  localparam int STAGES = 2;
  localparam int DEPTH  = 4;

  typedef struct {
    cdb_t val;
    int   rdy_cyc;
  } exp_ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  logic kat_en;
  logic [31:0] kat_val;
  exp_ent_t q[$];

  alu_pipe_if bus ();

  alu_pipe #(.STAGES(STAGES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      reg_add, imm_addi, lui, auipc: return a + b;
      reg_sub:                       return a + ~b + 32'd1;
      reg_sll, imm_slli:             return a << sh;
      reg_srl, imm_srli:             return a >> sh;
      reg_sra, imm_srai:             return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      reg_xor, imm_xori:             return a ^ b;
      reg_or,  imm_ori:              return a | b;
      reg_and, imm_andi:             return a & b;
      reg_slt, imm_slti:             return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      reg_sltu, imm_sltiu:           return (a < b) ? 32'd1 : 32'd0;
      jal:                           return a + 32'd4;
      default:                       return 32'd0;
    endcase
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic start, input alu_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] rob, input logic crdy,
                      input logic fl);
    logic     exp_v;
    logic     exp_rdy;
    cdb_t     exp_r;
    logic     fire;
    logic     popx;
    exp_ent_t e;
    @(negedge clk);
    exp_v   = (q.size() > 0) && (q[0].rdy_cyc <= cyc);
    exp_r   = exp_v ? q[0].val : '0;
    exp_rdy = (q.size() < DEPTH);
    check_eq("alu_ready", 128'(bus.alu_ready), 128'(exp_rdy));
    check_eq("result_valid", 128'(bus.alu_result_valid), 128'(exp_v));
    check_eq("result", 128'(bus.result), 128'(exp_r));
    bus.rs_alu_start       = start;
    bus.data.op            = op;
    bus.data.q1_data       = a;
    bus.data.q2_data       = b;
    bus.data.rob_dest      = rob;
    bus.cdb_ready          = crdy;
    bus.flush              = fl;
    fire = start && exp_rdy;
    popx = exp_v && crdy;
    e.val.rd_data   = kat_en ? kat_val : ref_alu(op, a, b);
    e.val.rs1_data  = a;
    e.val.rs2_data  = b;
    e.val.rob_entry = rob;
    e.rdy_cyc       = cyc + STAGES;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (popx) void'(q.pop_front());
      if (fire) q.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input logic crdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, reg_add, 32'd0, 32'd0, 4'd0, crdy, 1'b0);
  endtask

  task automatic kat(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    kat_en  = 1'b1;
    kat_val = exp;
    step(1'b1, op, a, b, 4'd9, 1'b1, 1'b0);
    kat_en  = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    kat_en = 1'b0;
    kat_val = '0;
    rst = 1'b0;
    bus.rs_alu_start = 1'b0;
    bus.data = '0;
    bus.flush = 1'b0;
    bus.cdb_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_eq("reset_ready", 128'(bus.alu_ready), 128'(1'b1));
    check_eq("reset_valid", 128'(bus.alu_result_valid), 128'(1'b0));
    check_eq("reset_result", 128'(bus.result), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic add with operand/rob capture, then the op-table corner cases
    step(1'b1, reg_add, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0);
    idle(1'b1, 3);
    kat(imm_srai, 32'h8000_0000, 32'd4, 32'hF800_0000);
    kat(reg_sltu, 32'd1, 32'hFFFF_FFFF, 32'd1);
    kat(reg_slt, 32'd1, 32'hFFFF_FFFF, 32'd0);
    kat(jal, 32'h100, 32'd0, 32'h104);
    kat(alu_op_t'(5'd31), 32'h1234, 32'h5678, 32'd0);
    kat(reg_sub, 32'd0, 32'd1, 32'hFFFF_FFFF);
    kat(reg_add, 32'hFFFF_FFFF, 32'd1, 32'd0);
    idle(1'b1, 4);

    // Backpressure: fill to DEPTH, fifth issue is refused, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, reg_xor, 32'(i * 17), 32'hA5A5_0000, 4'(i), 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 6);

    // Sustained stream with CDB always ready
    for (int i = 0; i < 20; i++)
      step(1'b1, reg_add, 32'(i), 32'(1000 + i), 4'(i), 1'b1, 1'b0);
    idle(1'b1, 4);

    // Flush with results in flight and a colliding issue
    for (int i = 0; i < 3; i++)
      step(1'b1, reg_or, 32'(i), 32'h10, 4'(i), 1'b0, 1'b0);
    idle(1'b0, 1);
    step(1'b1, reg_and, 32'hFF, 32'h0F, 4'd7, 1'b1, 1'b1);
    idle(1'b1, 4);

    // Asynchronous reset between edges with work in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, reg_sll, 32'd1, 32'(i), 4'(i), 1'b0, 1'b0);
    @(negedge clk);
    bus.rs_alu_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_ready", 128'(bus.alu_ready), 128'(1'b1));
    check_eq("async_rst_valid", 128'(bus.alu_result_valid), 128'(1'b0));
    check_eq("async_rst_result", 128'(bus.result), 128'(0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, reg_add, 32'd40, 32'd2, 4'd5, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), alu_op_t'(5'($urandom_range(0, 31))), rnd_word(),
           rnd_word(), 4'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
    idle(1'b1, DEPTH + STAGES + 2);
    check_eq("drained", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU functional unit for the Tomasulo RV32I core. It sits between the ALU reservation station and the common data bus (CDB). It accepts one operation per cycle and computes it over a configurable number of pipeline stages. Completed results are buffered in an internal result FIFO until the CDB arbiter takes them, so back-to-back issue continues while the CDB is busy. In-flight work is discarded on a pipeline flush.

## Interface
- STAGES, 1: execute latency in cycles; legal 1..4.
- DEPTH, 4: max operations in flight (pipeline + result FIFO); power of two, DEPTH >= STAGES, legal 2..16.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- data  in  rs_alu_output_t  operation, q1_data, q2_data, rob_dest from the reservation station.
- rs_alu_start  in  1  issue strobe; accepted only when alu_ready is high.
- flush  in  1  kill all in-flight and buffered results.
- cdb_ready  in  1  CDB accepts the current head result this cycle.
- alu_ready  out  1  unit can accept an issue this cycle.
- alu_result_valid  out  1  result holds a valid completed operation.
- result  out  cdb_t  rd_data, rs1_data, rs2_data, rob_entry of the FIFO head.

## Operation
- Issue fires when rs_alu_start && alu_ready. Operands and rob_dest are captured together with the computed f.
- Op table (au/bu unsigned, as/bs signed, shift amount is bu[4:0]):
  - add/addi/lui/auipc: au+bu.
  - sub: au-bu.
  - sll/slli, srl/srli: logical shifts.
  - sra/srai: arithmetic right shift of as.
  - xor/xori, or/ori, and/andi: bitwise.
  - slt/slti: signed compare. sltu/sltiu: unsigned compare. Both give 32'h1 or 32'h0.
  - jal: au+32'd4.
  - Any other op: f = 0, never X.
- All arithmetic is 32-bit modulo 2^32. The carry-out is dropped.
- f is computed combinationally at issue, then carried through STAGES-1 pipeline registers, each with a valid bit. The last stage writes into the result FIFO (alu_result_fifo).
- inflight counter = valid pipeline entries + FIFO occupancy.
  - +1 on issue; −1 on pop.
  - Issue and pop in the same cycle leave it unchanged.
  - The counter never exceeds DEPTH, so the FIFO never overflows and the pipeline never stalls.
- alu_ready = (inflight < DEPTH). It is computed from registered state only; no combinational path from cdb_ready or rs_alu_start.
- Pop occurs when alu_result_valid && cdb_ready. A pop on an empty FIFO is ignored.
- alu_result_valid = FIFO not empty. result = FIFO head; all fields are 0 when empty.
- Flush: on the next edge, all pipeline valid bits and the FIFO are cleared and inflight becomes 0.
  - An issue or pop in the flush cycle is discarded; flush wins.
  - alu_ready is high the cycle after a flush.

## Timing
- Reset values: alu_ready=1, alu_result_valid=0, result=0, inflight=0, all valid bits 0.
- rst may assert mid-operation; all state clears immediately, with no partial results.
- Latency: an issue at edge k makes the result visible (alu_result_valid high) after edge k+STAGES−1+1, i.e. STAGES cycles after the issue cycle. STAGES=1 gives one-cycle latency.
- Throughput: one issue per cycle sustained when cdb_ready is held high and DEPTH >= STAGES+1.
- Ordering: results leave in issue order (in-order within the unit).
- Full: at inflight=DEPTH, alu_ready=0. A pop that cycle raises alu_ready the following cycle.
- Empty with cdb_ready high: no effect; alu_result_valid stays 0.
- A result write into an empty FIFO and a pop cannot coincide; a pop requires a visible head.
- result is stable while alu_result_valid && !cdb_ready.

## Structure
- rv32i_types holds: the op enum, rs_alu_output_t, cdb_t, and a shared alu_compute function (the op table) for reuse by other units.
- Sub-module alu_result_fifo: parametrised DEPTH × cdb_t.
  - Registered head/tail pointers with wrap-around and a count.
  - Ports: push, pop, flush, full, empty.
- Pipeline registers live in alu_pipe as an array indexed 1..STAGES-1. It is generate-guarded for STAGES=1.

## Test plan
- STAGES=2, DEPTH=4, cdb_ready=1. Issue reg_add 5+7 at cycle 0 with rob_dest=3 → alu_result_valid at cycle 2, rd_data=12, rob_entry=3, rs1_data=5, rs2_data=7.
- Sweep the op table: imm_srai 0x80000000 by 4 → 0xF8000000. reg_sltu 1 vs 0xFFFFFFFF → 1. reg_slt 1 vs 0xFFFFFFFF → 0. jal q1=0x100 → 0x104. Unknown op → 0.
- cdb_ready=0 with 4 back-to-back issues → alu_ready drops after the 4th issue, and the 5th rs_alu_start is ignored. Then raise cdb_ready → 4 results pop in issue order, one per cycle, and alu_ready returns 1 the cycle after the first pop.
- Sustained stream: 20 issues with cdb_ready=1 → alu_ready never drops, 20 results arrive in order, one per cycle, with STAGES latency.
- With 3 results in flight, assert flush together with a new issue → the next cycle has alu_result_valid=0 and alu_ready=1, and no stale result ever appears.
- Assert rst asynchronously mid-stream, between clock edges → outputs go to reset values before the next edge, and operation resumes cleanly after deassertion.
